// File: rtl/pong_game_fsm.sv
// pong_game_fsm: game-flow controller for the pong design.
// Sequences idle / play / serve / pause / game-over for 2..4 players. It keeps
// one saturating score per player so it can end the game early and pick the
// winner. A frame-tick timer paces the serve and game-over waits.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   frame_tick       one-cycle pulse per video frame
//   btn              per-player serve/start level (synchronised)
//   pause_btn        pause level (synchronised)
//   miss             per-player one-cycle miss pulse
//   gra_still        freeze ball and paddles
//   score_clr        clear external score counters
//   score_inc        per-player one-cycle credit pulse
//   balls_left       balls still to be served
//   state            0 idle, 1 play, 2 serve, 3 pause, 4 over
//   winner           index+1 of the last winner, 0 = none or tie
module pong_game_fsm #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned BALLS       = 3,
  parameter int unsigned WIN_SCORE   = 0,
  parameter int unsigned WAIT_FRAMES = 120
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_tick,
  input  logic [NUM_PLAYERS-1:0]         btn,
  input  logic                           pause_btn,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic                           gra_still,
  output logic                           score_clr,
  output logic [NUM_PLAYERS-1:0]         score_inc,
  output logic [$clog2(BALLS+1)-1:0]     balls_left,
  output logic [2:0]                     state,
  output logic [2:0]                     winner
);

  localparam int unsigned BW     = $clog2(BALLS + 1);
  localparam int unsigned SW_RAW = $clog2(WIN_SCORE + 1);
  localparam int unsigned SW     = (SW_RAW < 1) ? 1 : SW_RAW;

  localparam logic [SW-1:0] SMax       = '1;
  localparam logic [SW-1:0] WinS       = SW'(WIN_SCORE);
  localparam logic [9:0]    WaitF      = 10'(WAIT_FRAMES);
  localparam logic [BW-1:0] BallsInit  = BW'(BALLS);
  localparam logic [BW-1:0] BallsFirst = BW'(BALLS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StServe = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [NUM_PLAYERS-1:0]         btn_q, score_inc_q, score_inc_d;
  logic                           pause_q;
  logic [NUM_PLAYERS-1:0][SW-1:0] score_q, score_d, score_upd;
  logic [BW-1:0]                  balls_q, balls_d;
  logic [9:0]                     timer_q, timer_d;
  logic [2:0]                     winner_q, winner_d, winner_calc;
  logic                           gra_still_q, gra_still_d;
  logic                           score_clr_q, score_clr_d;
  logic [NUM_PLAYERS-1:0]         press;
  logic                           ppress, timer_up, win_hit;

  assign press    = btn & ~btn_q;
  assign ppress   = pause_btn & ~pause_q;
  assign timer_up = (timer_q == WaitF);

  // Scores as they would be after crediting this cycle's misses.
  always_comb begin
    score_upd = score_q;
    win_hit   = 1'b0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      if (miss[p] && (score_q[p] != SMax)) score_upd[p] = score_q[p] + 1'b1;
      if ((WIN_SCORE != 0) && (score_upd[p] >= WinS)) win_hit = 1'b1;
    end
  end

  // Strictly highest updated score wins; any tie at the top gives 0.
  always_comb begin
    logic [SW-1:0] best;
    logic [1:0]    best_idx;
    logic          tie;
    best     = score_upd[0];
    best_idx = 2'd0;
    tie      = 1'b0;
    for (int p = 1; p < int'(NUM_PLAYERS); p++) begin
      if (score_upd[p] > best) begin
        best     = score_upd[p];
        best_idx = 2'(p);
        tie      = 1'b0;
      end else if (score_upd[p] == best) begin
        tie = 1'b1;
      end
    end
    winner_calc = tie ? 3'd0 : (3'(best_idx) + 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    balls_d     = balls_q;
    timer_d     = timer_q;
    winner_d    = winner_q;
    score_inc_d = '0;
    case (state_q)
      StIdle: begin
        score_d = '0;
        balls_d = BallsInit;
        if (|press) begin
          state_d  = StPlay;
          balls_d  = BallsFirst;
          winner_d = 3'd0;
        end
      end
      StPlay: begin
        if (|miss) begin
          score_inc_d = miss;
          score_d     = score_upd;
          timer_d     = '0;
          if ((balls_q == '0) || win_hit) begin
            state_d  = StOver;
            winner_d = winner_calc;
          end else begin
            // Only a ball that is going to be served is consumed.
            state_d = StServe;
            balls_d = balls_q - 1'b1;
          end
        end else if (ppress) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (ppress) state_d = StPlay;
      end
      StServe: begin
        if (timer_up && (|press)) state_d = StPlay;
        else if (frame_tick && !timer_up) timer_d = timer_q + 10'd1;
      end
      StOver: begin
        if (timer_up) begin
          state_d = StIdle;
          score_d = '0;
          balls_d = BallsInit;
          timer_d = '0;
        end else if (frame_tick) begin
          timer_d = timer_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    gra_still_d = (state_d != StPlay);
    score_clr_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      btn_q       <= '1;
      pause_q     <= 1'b1;
      score_q     <= '0;
      balls_q     <= BallsInit;
      timer_q     <= '0;
      winner_q    <= 3'd0;
      score_inc_q <= '0;
      gra_still_q <= 1'b1;
      score_clr_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn;
      pause_q     <= pause_btn;
      score_q     <= score_d;
      balls_q     <= balls_d;
      timer_q     <= timer_d;
      winner_q    <= winner_d;
      score_inc_q <= score_inc_d;
      gra_still_q <= gra_still_d;
      score_clr_q <= score_clr_d;
    end
  end

  assign gra_still  = gra_still_q;
  assign score_clr  = score_clr_q;
  assign score_inc  = score_inc_q;
  assign balls_left = balls_q;
  assign state      = state_q;
  assign winner     = winner_q;

endmodule

// File: doc/pong_game_fsm.md
# pong_game_fsm

Parametrised game-flow controller for the pong design. It replaces the fixed two-player newgame/play/newball/over sequencer with one that supports 2–4 players, a configurable ball count, an optional win score, a pause mode and an internal frame-based timer. It sits between the input front end (buttons or keyboard), the graphics unit (`miss` in, `gra_still` out) and the score/text units (score pulses, ball count, state and winner out).

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players/paddles; legal range 2..4.
- BALLS, 3, balls per game; legal range 1..15.
- WIN_SCORE, 0, points a player needs to end the game early; 0 disables early end; legal range 0..99.
- WAIT_FRAMES, 120, frame ticks for the serve and game-over waits (2 s at 60 Hz); legal range 1..1023.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame, on clk.
- btn  in  NUM_PLAYERS  level "serve/start" request, one bit per player, already synchronised.
- pause_btn  in  1  level pause request, already synchronised.
- miss  in  NUM_PLAYERS  one-cycle pulse; bit p means player p missed the ball.
- gra_still  out  1  freezes ball and paddle motion.
- score_clr  out  1  clears the external score counters.
- score_inc  out  NUM_PLAYERS  one-cycle pulse crediting player p.
- balls_left  out  $clog2(BALLS+1)  balls still to be served.
- state  out  3  encoded state (see Operation).
- winner  out  3  player index + 1 of the last-game winner; 0 = none or tie.

## Operation
- States: IDLE=0, PLAY=1, SERVE=2, PAUSE=3, OVER=4. Codes 5–7 are unreachable and recover to IDLE on the next clock.
- Press detection: `press = btn & ~btn_q` and `ppress = pause_btn & ~pause_q`. On reset the history registers go to all ones, so a button held through reset is not a press.
- Internal scores: one per player, SW = max(1, $clog2(WIN_SCORE+1)) bits wide, saturating at 2^SW−1.
- IDLE: gra_still=1, score_clr=1, internal scores held at 0, balls_left=BALLS. Any bit of `press` → PLAY, with balls_left=BALLS−1 and winner=0.
- PLAY: gra_still=0.
  - On a cycle with any `miss` bit set, for each p with miss[p]=1: score_inc[p]=1 and internal score p increments. Credit goes to the player who missed; the score unit maps this to the opponent.
  - Simultaneous misses are all credited, but balls_left decrements by only 1.
  - Next state is OVER if balls_left==0 or any updated score ≥ WIN_SCORE (when WIN_SCORE≠0); otherwise SERVE. In both cases the timer is cleared and started.
  - If `ppress` and no miss occur in the same cycle → PAUSE. Miss takes priority over pause.
- PAUSE: gra_still=1; `miss` and `press` are ignored. `ppress` → PLAY.
- SERVE: gra_still=1; the timer counts frame ticks. Once timer_up, any `press` → PLAY. A press before timer_up is ignored and is not remembered.
- OVER: gra_still=1; winner holds the index+1 of the strictly highest post-update score, or 0 if the top score is tied. When timer_up → IDLE.
- Timer: 10-bit counter, cleared on entry to SERVE/OVER, increments on `frame_tick`, saturates at WAIT_FRAMES. timer_up = (count == WAIT_FRAMES). The counter is idle in all other states.
- balls_left never underflows: the decrement applies only when the value is nonzero.

## Timing
- All outputs are registered and update on the clk edge after the causing input sample (1-cycle latency).
- score_inc is high for exactly one cycle, coincident with state leaving PLAY.
- In IDLE, score_clr is high on every cycle, including the first cycle after reset release.
- The state transition and the gra_still change take effect on the same edge.
- Reset values: state=IDLE, gra_still=1, score_clr=1, score_inc=0, balls_left=BALLS, winner=0, timer=0, internal scores=0.
- reset_n asserted mid-game: all registers return to reset values immediately (asynchronously). There is no pulse on score_inc.
- A frame_tick and a state entry in the same cycle: the counter clears; that tick is not counted.
- Serve wait = WAIT_FRAMES frame ticks after SERVE entry; with the default, the earliest PLAY is on the cycle after the 120th tick plus a press edge.

## Test plan
- Reset with btn held high (NUM_PLAYERS=2) → state=0, gra_still=1, score_clr=1, balls_left=3, winner=0; no transition until btn is released and pressed again.
- BALLS=3, WIN_SCORE=0: press btn[0]; then apply miss[1] three times, each in PLAY after a serve. Required: balls_left 2→1→0, states 1→2→1→2→1→4, three single-cycle score_inc[1] pulses, winner=2, and IDLE after 120 frame ticks in OVER.
- Simultaneous miss=2'b11 in PLAY → score_inc=2'b11 for one cycle, balls_left decrements by exactly 1, state=SERVE.
- WIN_SCORE=2, BALLS=15: miss[0] twice → OVER after the second miss with balls_left=13 and winner=1.
- In SERVE, press at tick 50 → stays in SERVE; press after tick 120 → PLAY next cycle.
- In PLAY, ppress → PAUSE with gra_still=1; a miss pulse during PAUSE causes no score_inc; ppress again → PLAY. Separately, ppress and miss in the same cycle → SERVE.
- Drive reset_n low for 3 ns in mid-PLAY, off a clk edge → all outputs at reset values immediately.
